// File: rtl/fft_pkg.sv
// Shared types, constants and helpers for the 8-point forward/inverse FFT cores.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam logic signed [15:0] TW_C = 16'sh5A82;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } fft_state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -19'sd32768) begin
      return 16'sh8000;
    end else begin
      return 16'(v);
    end
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 butterfly with conjugated twiddles and 1/2 stage scaling.
module ifft_bfly
  import fft_pkg::*;
(
  input  logic signed [15:0] a_real,
  input  logic signed [15:0] a_imag,
  input  logic signed [15:0] b_real,
  input  logic signed [15:0] b_imag,
  input  logic [1:0]         k,
  output logic signed [15:0] sum_real,
  output logic signed [15:0] sum_imag,
  output logic signed [15:0] diff_real,
  output logic signed [15:0] diff_imag
);

  logic signed [15:0] tw_real, tw_imag;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] m_real, m_imag;
  logic signed [17:0] t_real, t_imag;
  logic signed [18:0] s_real, s_imag, d_real, d_imag;

  always_comb begin
    tw_real = '0;
    tw_imag = '0;
    case (k)
      2'd1:    begin tw_real = TW_C;  tw_imag = TW_C; end
      2'd3:    begin tw_real = -TW_C; tw_imag = TW_C; end
      default: begin tw_real = '0;    tw_imag = '0;   end
    endcase
  end

  assign p_rr = b_real * tw_real;
  assign p_ii = b_imag * tw_imag;
  assign p_ri = b_real * tw_imag;
  assign p_ir = b_imag * tw_real;

  // Round-half-up before the Q15 renormalising shift
  assign m_real = 33'(p_rr) - 33'(p_ii) + 33'sd16384;
  assign m_imag = 33'(p_ri) + 33'(p_ir) + 33'sd16384;

  always_comb begin
    t_real = '0;
    t_imag = '0;
    case (k)
      2'd0: begin
        t_real = 18'(b_real);
        t_imag = 18'(b_imag);
      end
      2'd2: begin
        t_real = -18'(b_imag);
        t_imag = 18'(b_real);
      end
      default: begin
        t_real = 18'(m_real >>> 15);
        t_imag = 18'(m_imag >>> 15);
      end
    endcase
  end

  assign s_real = 19'(a_real) + 19'(t_real);
  assign s_imag = 19'(a_imag) + 19'(t_imag);
  assign d_real = 19'(a_real) - 19'(t_real);
  assign d_imag = 19'(a_imag) - 19'(t_imag);

  assign sum_real  = sat16(s_real >>> 1);
  assign sum_imag  = sat16(s_imag >>> 1);
  assign diff_real = sat16(d_real >>> 1);
  assign diff_imag = sat16(d_imag >>> 1);

endmodule

// File: rtl/ifft_8_sol1.sv
// Iterative 8-point radix-2 DIT inverse FFT sharing one butterfly; 1/8 scaling built in.
module ifft_8_sol1
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] data_in_real  [8],
  input  logic signed [DATA_W-1:0] data_in_imag  [8],
  output logic signed [DATA_W-1:0] data_out_real [8],
  output logic signed [DATA_W-1:0] data_out_imag [8],
  output logic                     done,
  output logic                     busy
);

  fft_state_t state, state_next;
  logic load_en, calc_en, fin_en, last;

  logic [1:0] s, b, k;
  logic [2:0] idx_i, idx_j;

  logic signed [15:0] w_real [8];
  logic signed [15:0] w_imag [8];
  logic signed [15:0] sum_real, sum_imag, diff_real, diff_imag;

  assign last = (state == CALC) && (s == 2'd2) && (b == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    load_en = (state == LOAD);
    calc_en = (state == CALC);
    fin_en  = (state == DONE);
  end

  // i = (b/h)*2h + b%h built by inserting a zero at bit s of b; j sets that bit
  always_comb begin
    idx_i = '0;
    k     = '0;
    case (s)
      2'd0: begin
        idx_i = {b, 1'b0};
        k     = 2'd0;
      end
      2'd1: begin
        idx_i = {b[1], 1'b0, b[0]};
        k     = {b[0], 1'b0};
      end
      default: begin
        idx_i = {1'b0, b};
        k     = b;
      end
    endcase
    idx_j = idx_i | (3'd1 << s);
  end

  ifft_bfly u_bfly (
    .a_real    (w_real[idx_i]),
    .a_imag    (w_imag[idx_i]),
    .b_real    (w_real[idx_j]),
    .b_imag    (w_imag[idx_j]),
    .k         (k),
    .sum_real  (sum_real),
    .sum_imag  (sum_imag),
    .diff_real (diff_real),
    .diff_imag (diff_imag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s    <= '0;
      b    <= '0;
      done <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) begin
        w_real[n]        <= '0;
        w_imag[n]        <= '0;
        data_out_real[n] <= '0;
        data_out_imag[n] <= '0;
      end
    end else begin
      done <= fin_en;
      if (load_en) begin
        s <= '0;
        b <= '0;
        for (int unsigned n = 0; n < 8; n++) begin
          w_real[n] <= data_in_real[bitrev3(3'(n))];
          w_imag[n] <= data_in_imag[bitrev3(3'(n))];
        end
      end
      if (calc_en) begin
        w_real[idx_i] <= sum_real;
        w_imag[idx_i] <= sum_imag;
        w_real[idx_j] <= diff_real;
        w_imag[idx_j] <= diff_imag;
        if (last) begin
          s <= '0;
          b <= '0;
        end else if (b == 2'd3) begin
          s <= s + 2'd1;
          b <= '0;
        end else begin
          b <= b + 2'd1;
        end
      end
      if (fin_en) begin
        for (int unsigned n = 0; n < 8; n++) begin
          data_out_real[n] <= w_real[n];
          data_out_imag[n] <= w_imag[n];
        end
      end
    end
  end

endmodule

// File: doc/ifft_8_sol1.md
# ifft_8_sol1

Iterative 8-point radix-2 decimation-in-time inverse FFT. It is the return path for the `fft_8_sol1_gen3` forward transform and uses the same start/done handshake and the same parallel complex array ports. It loads eight complex Q1.15 samples and runs 12 butterflies on one shared butterfly unit. Each stage scales by 1/2, so the total 1/8 normalisation is built in. Results are held on the outputs until the next completion.

## Interface
- `DATA_W`, 16, sample width. Only 16 is supported because the twiddles are Q1.15.
- `clk` in 1 — single clock. All state changes on the rising edge.
- `rst` in 1 — asynchronous, active-low reset. Asserted when 0.
- `start` in 1 — request a transform. Sampled only in IDLE.
- `data_in_real[7:0]` in 8×16 — real part of the time/frequency input, signed Q1.15.
- `data_in_imag[7:0]` in 8×16 — imaginary part of the input, signed Q1.15.
- `data_out_real[7:0]` out 8×16 — real part of the inverse transform, signed Q1.15, registered.
- `data_out_imag[7:0]` out 8×16 — imaginary part of the inverse transform, registered.
- `done` out 1 — one-cycle pulse. Outputs are valid from this cycle on.
- `busy` out 1 — high from LOAD through DONE inclusive.

## Operation
- FSM states: IDLE → LOAD → CALC → DONE → IDLE.
- **IDLE:** waits for `start`=1; `start` in any other state is ignored.
- **LOAD:** copies inputs into the internal working registers `wr/wi[0..7]` in bit-reversed order: `w[n] = x[bitrev3(n)]`, i.e. `w[1]=x[4]`, `w[3]=x[6]`.
- **CALC:** one butterfly per cycle. Stage counter `s` runs 0..2 and butterfly counter `b` runs 0..3. With `h = 1<<s`:
  - `i = (b/h)*2h + b%h`, `j = i+h`
  - twiddle index `k = (b%h)*(4/h)`
  - Leave CALC after `s=2, b=3`.
- Twiddles are conjugated (inverse transform), `W^-k = e^{+jπk/4}`, with c = 23170 (0x5A82):
  - k=0: `t = b`, no multiplier.
  - k=2: `t = (-bi, br)`, no multiplier.
  - k=1: `(c, c)`.
  - k=3: `(-c, c)`.
- Butterfly arithmetic:
  - Complex multiply: 16×16 products, summed at 33 bits, plus 2^14, then `>>>15` to an 18-bit `t`.
  - `a' = (a + t) >>> 1`, `b' = (a − t) >>> 1`. Intermediates are 19 bits; the shift truncates toward −∞.
  - Results saturate to [−32768, 32767].
  - Writeback to `w[i]`, `w[j]` happens on the same edge.
- **DONE:** copies `w[0..7]` to `data_out_*`, pulses `done` and returns to IDLE.
- Outputs hold their values until the next DONE.
- **Reset:** async assertion at any point forces IDLE. `done`=0, `busy`=0, all `data_out_*`=0, all `w`=0 and counters=0.
  - A mid-transform reset discards the transform; no `done` is produced.
  - After release, the first rising edge with `start`=1 behaves normally.

## Timing
- `start` is sampled high at edge E0 (in IDLE).
- LOAD executes at E1.
- Butterflies execute at E2..E13.
- The DONE edge is E14; `done`=1 and new outputs are visible for the cycle after E14.
- Latency is 14 cycles from the start-sampling edge to done.
- IDLE is re-entered at E15, so the earliest next accepted `start` is sampled at E15. Throughput is one transform per 15 cycles.
- Inputs are sampled only at the LOAD edge. They may change at any other time without effect.

## Structure
- Shared package `fft_pkg` holds:
  - `DATA_W`
  - the twiddle constant `TW_C = 16'sh5A82`
  - the FSM state enum `fft_state_t` (IDLE/LOAD/CALC/DONE)
  - the `bitrev3` function
  - the saturation function `sat16`
- Sub-module `ifft_bfly` is the combinational butterfly with a 2-bit twiddle index. Inputs are `a`, `b`, `k`; outputs are `a'`, `b'`. It contains the rounding, shifting and saturation.
- The top level holds the FSM, the counters, the working register file and the output registers.

## Test plan
- **Impulse:** `x[0]=0x4000`, all others 0 → all `out_real=0x0800`, all `out_imag=0`. `done` arrives exactly 14 cycles after the start edge.
- **DC:** all `x_real=0x4000`, imag 0 → `out[0]=(0x4000,0)`; `out[1..7]=(0,0)` within ±1 LSB.
- **Shifted impulse:** `x[1]=0x4000` → `out[n] ≈ 0x0800·e^{+jπn/4}`, within ±2 LSB:
  - `out[0]=(0x0800,0)`
  - `out[1]≈(0x05A8,0x05A8)`
  - `out[2]=(0,0x0800)`
  - `out[4]=(0xF800,0)`
- **Full-scale negative DC:** all `x_real=0x8000` → `out[0]=(0x8000,0)`, others 0. No wrap to positive.
- **Control:** a `start` pulse during CALC is ignored, giving a single `done`. Holding `start` high continuously gives a `done` every 15 cycles.
- **Reset mid-CALC:** assert `rst`=0 at cycle 6 → `busy`, `done` and outputs go to 0 asynchronously, and no `done` follows. A fresh impulse transform after release produces the correct result.
